// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 command codes, scheduler states and source encodings
package ps2_pkg;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;

    localparam logic [1:0] SRC_BOOT = 2'd0;
    localparam logic [1:0] SRC_LED  = 2'd1;
    localparam logic [1:0] SRC_HOST = 2'd2;

    typedef enum logic [2:0] {
        BOOT_SEND,
        BOOT_WAIT,
        IDLE,
        SEND_CMD,
        WAIT_CMD,
        SEND_ARG,
        WAIT_ARG,
        DONE
    } ps2_state_e;

endpackage

// File: rtl/ps2_command_scheduler.sv
// rtl/ps2_command_scheduler.sv - sequences boot, LED and raw host commands onto the PS/2 command channel
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   led_valid/led_ready/led_state   LED update request (0xED + {caps,num,scroll})
//   host_valid/host_ready/host_byte raw host command request
//   command_valid/ready/byte        byte stream to the protocol engine
//   command_ack_valid/ready/error   per-byte acknowledge from the protocol engine
//   done_valid/error/source         one-cycle transaction completion report
//   busy                            high whenever not idle
module ps2_command_scheduler
    import ps2_pkg::*;
#(
    parameter int MAX_RETRIES = 3,
    parameter int ACK_TIMEOUT = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       led_valid,
    output logic       led_ready,
    input  logic [2:0] led_state,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic [7:0] host_byte,
    output logic       command_valid,
    input  logic       command_ready,
    output logic [7:0] command_byte,
    input  logic       command_ack_valid,
    output logic       command_ack_ready,
    input  logic       command_ack_error,
    output logic       done_valid,
    output logic       done_error,
    output logic [1:0] done_source,
    output logic       busy
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRIES);

    ps2_state_e    r_state;
    ps2_state_e    w_next;
    logic [3:0]    r_retry;
    logic [TW-1:0] r_timer;
    logic          r_is_led;
    logic [7:0]    r_arg;
    logic [7:0]    r_cmd_byte;
    logic          r_error;
    logic [1:0]    r_source;

    logic w_send;
    logic w_wait;
    logic w_fire;
    logic w_ack_ok;
    logic w_fail;
    logic w_can_retry;
    logic w_led_take;
    logic w_host_take;

    always_comb begin
        w_send      = (r_state == BOOT_SEND) || (r_state == SEND_CMD) || (r_state == SEND_ARG);
        w_wait      = (r_state == BOOT_WAIT) || (r_state == WAIT_CMD) || (r_state == WAIT_ARG);
        w_fire      = w_send && command_ready;
        w_ack_ok    = w_wait && command_ack_valid && !command_ack_error;
        // An ack arriving in the timeout cycle takes precedence over the timeout.
        w_fail      = w_wait && ((command_ack_valid && command_ack_error) ||
                                 (!command_ack_valid && (r_timer == TIMER_LAST)));
        w_can_retry = (r_retry < RETRY_MAX);
        w_led_take  = (r_state == IDLE) && led_valid;
        w_host_take = (r_state == IDLE) && !led_valid && host_valid;

        w_next = r_state;
        case (r_state)
            BOOT_SEND: if (command_ready) w_next = BOOT_WAIT;
            BOOT_WAIT: begin
                if (w_ack_ok)   w_next = DONE;
                else if (w_fail) w_next = w_can_retry ? BOOT_SEND : DONE;
            end
            IDLE:      if (led_valid || host_valid) w_next = SEND_CMD;
            SEND_CMD:  if (command_ready) w_next = WAIT_CMD;
            WAIT_CMD: begin
                if (w_ack_ok)    w_next = r_is_led ? SEND_ARG : DONE;
                else if (w_fail) w_next = w_can_retry ? SEND_CMD : DONE;
            end
            SEND_ARG:  if (command_ready) w_next = WAIT_ARG;
            WAIT_ARG: begin
                // A failed argument is resent on its own; 0xED is not repeated.
                if (w_ack_ok)    w_next = DONE;
                else if (w_fail) w_next = w_can_retry ? SEND_ARG : DONE;
            end
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase

        // State sits in BOOT_SEND during reset; the valid is masked so outputs read 0 then.
        command_valid     = w_send && !reset;
        command_ack_ready = w_wait;
        command_byte      = r_cmd_byte;
        led_ready         = w_led_take;
        host_ready        = w_host_take;
        done_valid        = (r_state == DONE);
        done_error        = (r_state == DONE) && r_error;
        done_source       = (r_state == DONE) ? r_source : SRC_BOOT;
        busy              = (r_state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= BOOT_SEND;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retry    <= '0;
            r_timer    <= '0;
            r_is_led   <= 1'b0;
            r_arg      <= '0;
            r_cmd_byte <= PS2_CMD_RESET;
            r_error    <= 1'b0;
            r_source   <= SRC_BOOT;
        end else begin
            if (w_fire)
                r_timer <= '0;
            else if (w_wait && (r_timer != TIMER_LAST))
                r_timer <= r_timer + 1'b1;

            if (w_ack_ok || (w_fail && !w_can_retry))
                r_retry <= '0;
            else if (w_fail)
                r_retry <= r_retry + 1'b1;

            if (w_led_take || w_host_take)
                r_error <= 1'b0;
            else if (w_fail && !w_can_retry)
                r_error <= 1'b1;

            if (w_led_take) begin
                r_is_led   <= 1'b1;
                r_arg      <= {5'b0, led_state};
                r_cmd_byte <= PS2_CMD_SET_LEDS;
                r_source   <= SRC_LED;
            end else if (w_host_take) begin
                r_is_led   <= 1'b0;
                r_cmd_byte <= host_byte;
                r_source   <= SRC_HOST;
            end else if ((r_state == WAIT_CMD) && w_ack_ok && r_is_led) begin
                r_cmd_byte <= r_arg;
            end
        end
    end

endmodule

// File: tb/tb_ps2_command_scheduler.sv
// tb/tb_ps2_command_scheduler.sv - directed self-checking bench for ps2_command_scheduler
module tb_ps2_command_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       led_valid = 1'b0;
    logic       led_ready;
    logic [2:0] led_state = 3'b000;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic [7:0] host_byte = 8'h00;
    logic       command_valid;
    logic       command_ready = 1'b1;
    logic [7:0] command_byte;
    logic       command_ack_valid = 1'b0;
    logic       command_ack_ready;
    logic       command_ack_error = 1'b0;
    logic       done_valid;
    logic       done_error;
    logic [1:0] done_source;
    logic       busy;

    ps2_command_scheduler #(.MAX_RETRIES(3), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .led_valid(led_valid), .led_ready(led_ready), .led_state(led_state),
        .host_valid(host_valid), .host_ready(host_ready), .host_byte(host_byte),
        .command_valid(command_valid), .command_ready(command_ready), .command_byte(command_byte),
        .command_ack_valid(command_ack_valid), .command_ack_ready(command_ack_ready),
        .command_ack_error(command_ack_error),
        .done_valid(done_valid), .done_error(done_error), .done_source(done_source),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // ack_mode per absolute handshake index: 0 = ack ok, 1 = ack error, 2 = never ack
    logic [1:0] ack_mode [0:255];
    logic [7:0] sent_q[$];
    int         hs_cyc[$];
    logic [3:0] done_q[$];
    int         cyc = 0;
    int         led_cnt = 0;
    int         host_cnt = 0;
    logic       hs_pend = 1'b0;
    logic       ack_taken = 1'b0;
    int         hs_idx = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    // Observation half of the protocol-engine model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            hs_pend   = command_valid && command_ready;
            ack_taken = command_ack_valid && command_ack_ready;
            if (hs_pend) begin
                sent_q.push_back(command_byte);
                hs_cyc.push_back(cyc);
                hs_idx = sent_q.size() - 1;
            end
            if (done_valid) done_q.push_back({busy, done_error, done_source});
            if (led_ready)  led_cnt++;
            if (host_ready) host_cnt++;
        end else begin
            hs_pend   = 1'b0;
            ack_taken = 1'b0;
        end
    end

    // Driving half: acks are presented the cycle after a handshake, held until consumed.
    always @(posedge clk) begin
        logic [1:0] m;
        cyc++;
        #1;
        if (reset) begin
            command_ack_valid = 1'b0;
        end else begin
            if (ack_taken) command_ack_valid = 1'b0;
            if (hs_pend) begin
                m = ack_mode[hs_idx];
                if (m != 2'd2) begin
                    command_ack_valid = 1'b1;
                    command_ack_error = m[0];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_sent(input string tag, input int n);
        int t = 0;
        while (sent_q.size() < n && t < 500) begin
            @(posedge clk); #2; t++;
        end
        if (sent_q.size() < n) check(tag, sent_q.size(), n);
    endtask

    task automatic wait_done(input string tag, input int n);
        int t = 0;
        while (done_q.size() < n && t < 500) begin
            @(posedge clk); #2; t++;
        end
        if (done_q.size() < n) check(tag, done_q.size(), n);
    endtask

    // Holds each request until its ready pulse, then scrambles the inputs to prove latching.
    task automatic request(input logic do_led, input logic do_host,
                           input logic [2:0] ls, input logic [7:0] hb);
        int   t = 0;
        logic la, ha;
        @(posedge clk); #1;
        led_state  = ls;
        host_byte  = hb;
        led_valid  = do_led;
        host_valid = do_host;
        while ((led_valid || host_valid) && t < 500) begin
            @(negedge clk);
            la = led_ready;
            ha = host_ready;
            @(posedge clk); #1;
            if (la) begin led_valid = 1'b0; led_state = ~led_state; end
            if (ha) begin host_valid = 1'b0; host_byte = ~host_byte; end
            t++;
        end
        if (led_valid || host_valid) begin
            check("req_accept", 0, 1);
            led_valid  = 1'b0;
            host_valid = 1'b0;
        end
    endtask

    function automatic logic [7:0] sent_at(input int i);
        return (i < sent_q.size()) ? sent_q[i] : 8'hxx;
    endfunction

    function automatic logic [3:0] done_at(input int i);
        return (i < done_q.size()) ? done_q[i] : 4'hx;
    endfunction

    initial begin
        int sb, db, lb, hb;
        for (int i = 0; i < 256; i++) ack_mode[i] = 2'd0;

        // Reset state
        #2 reset = 1'b1;
        #1;
        check("rst_cmd_valid", command_valid, 0);
        check("rst_cmd_byte", command_byte, 8'hFF);
        check("rst_busy", busy, 1);
        check("rst_ack_ready", command_ack_ready, 0);
        check("rst_done", {done_valid, done_error, done_source}, 0);
        check("rst_readies", {led_ready, host_ready}, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Boot with immediate ack
        wait_done("boot_wait", 1);
        check("boot_byte", sent_at(0), 8'hFF);
        check("boot_nsent", sent_q.size(), 1);
        check("boot_done", done_at(0), 4'b1_0_00);
        check("boot_busy_after", busy, 0);

        // LED update 3'b101
        sb = sent_q.size(); db = done_q.size(); lb = led_cnt;
        request(1'b1, 1'b0, 3'b101, 8'h00);
        wait_done("led_wait", db + 1);
        check("led_cmd", sent_at(sb), 8'hED);
        check("led_arg", sent_at(sb + 1), 8'h05);
        check("led_nsent", sent_q.size() - sb, 2);
        check("led_done", done_at(db), 4'b1_0_01);
        check("led_ready_cycles", led_cnt - lb, 1);

        // Simultaneous LED and host: LED wins
        sb = sent_q.size(); db = done_q.size(); lb = led_cnt; hb = host_cnt;
        request(1'b1, 1'b1, 3'b011, 8'hF4);
        wait_done("prio_wait", db + 2);
        check("prio_b0", sent_at(sb), 8'hED);
        check("prio_b1", sent_at(sb + 1), 8'h03);
        check("prio_b2", sent_at(sb + 2), 8'hF4);
        check("prio_done0", done_at(db), 4'b1_0_01);
        check("prio_done1", done_at(db + 1), 4'b1_0_10);
        check("prio_readies", {led_cnt - lb, host_cnt - hb}, {32'd1, 32'd1});

        // Host 0xF4: three errors then success
        sb = sent_q.size(); db = done_q.size();
        for (int i = 0; i < 3; i++) ack_mode[sb + i] = 2'd1;
        request(1'b0, 1'b1, 3'b000, 8'hF4);
        wait_done("retry_ok_wait", db + 1);
        check("retry_ok_nsent", sent_q.size() - sb, 4);
        check("retry_ok_last", sent_at(sb + 3), 8'hF4);
        check("retry_ok_done", done_at(db), 4'b1_0_10);

        // Host 0xF4: four errors -> exhausted
        sb = sent_q.size(); db = done_q.size();
        for (int i = 0; i < 4; i++) ack_mode[sb + i] = 2'd1;
        request(1'b0, 1'b1, 3'b000, 8'hF4);
        wait_done("retry_fail_wait", db + 1);
        check("retry_fail_nsent", sent_q.size() - sb, 4);
        check("retry_fail_done", done_at(db), 4'b1_1_10);

        // No ack ever: 16 wait cycles + 1 send cycle between handshakes
        sb = sent_q.size(); db = done_q.size();
        for (int i = 0; i < 4; i++) ack_mode[sb + i] = 2'd2;
        request(1'b0, 1'b1, 3'b000, 8'h55);
        wait_done("timeout_wait", db + 1);
        check("timeout_nsent", sent_q.size() - sb, 4);
        for (int i = 0; i < 3; i++)
            check("timeout_spacing",
                  (sb + i + 1 < hs_cyc.size()) ? hs_cyc[sb + i + 1] - hs_cyc[sb + i] : -1, 17);
        check("timeout_done", done_at(db), 4'b1_1_10);

        // Argument NAK resends only the argument
        sb = sent_q.size(); db = done_q.size();
        ack_mode[sb + 1] = 2'd1;
        request(1'b1, 1'b0, 3'b110, 8'h00);
        wait_done("argretry_wait", db + 1);
        check("argretry_nsent", sent_q.size() - sb, 3);
        check("argretry_b0", sent_at(sb), 8'hED);
        check("argretry_b1", sent_at(sb + 1), 8'h06);
        check("argretry_b2", sent_at(sb + 2), 8'h06);
        check("argretry_done", done_at(db), 4'b1_0_01);

        // Reset asserted while waiting on the argument ack
        sb = sent_q.size(); db = done_q.size();
        ack_mode[sb + 1] = 2'd2;
        request(1'b1, 1'b0, 3'b001, 8'h00);
        wait_sent("abort_arg_wait", sb + 2);
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("abort_cmd_valid", command_valid, 0);
        check("abort_cmd_byte", command_byte, 8'hFF);
        check("abort_busy", busy, 1);
        check("abort_ack_ready", command_ack_ready, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wait_done("reboot_wait", db + 1);
        check("reboot_byte", sent_at(sb + 2), 8'hFF);
        check("reboot_nsent", sent_q.size() - sb, 3);
        check("reboot_done", done_at(db), 4'b1_0_00);
        repeat (3) @(posedge clk);
        #2;
        check("reboot_ndone", done_q.size() - db, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_command_scheduler.md
Name: ps2_command_scheduler

Overview:
Sequences all host-to-keyboard traffic onto the single command channel of the PS/2 protocol engine. At reset it runs a keyboard reset command (0xFF). Afterwards it arbitrates between LED updates (0xED plus an LED argument byte) and raw host commands. It waits for each byte's acknowledge, retries failed bytes and reports the completion status of every transaction.

Parameters:
MAX_RETRIES, 3, extra attempts per byte after the first attempt fails (0..15)
ACK_TIMEOUT, 2_000_000, clk cycles to wait in a WAIT state before declaring failure (~20 ms at 100 MHz)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
led_valid  in  1  LED update request
led_ready  out  1  LED request accepted (pulse)
led_state  in  3  {caps, num, scroll}; sent as argument bits [2:0], bits [7:3]=0
host_valid  in  1  raw command request
host_ready  out  1  raw command accepted (pulse)
host_byte  in  8  raw command byte
command_valid  out  1  to protocol engine
command_ready  in  1  protocol engine accepts byte
command_byte  out  8  byte to transmit
command_ack_valid  in  1  acknowledge result from protocol engine
command_ack_ready  out  1  scheduler consumes ack
command_ack_error  in  1  1 = device NAK / resend / framing failure
done_valid  out  1  transaction complete (1-cycle pulse)
done_error  out  1  transaction exhausted retries
done_source  out  2  0 = boot, 1 = led, 2 = host
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: all outputs 0, except busy=1; state=BOOT_SEND; retry=0; timer=0; command_byte=0xFF.
- States: BOOT_SEND, BOOT_WAIT, IDLE, SEND_CMD, WAIT_CMD, SEND_ARG, WAIT_ARG, DONE.
- SEND states:
  - command_valid=1 with a stable command_byte until command_valid & command_ready.
  - The handshake cycle moves to the matching WAIT state and clears the timer.
- WAIT states:
  - command_ack_ready=1.
  - On command_ack_valid with error=0: WAIT_CMD goes to SEND_ARG if the transaction is an LED update, otherwise to DONE. BOOT_WAIT and WAIT_ARG go to DONE. retry is cleared on every success.
  - On error=1, or when the timer reaches ACK_TIMEOUT-1: if retry<MAX_RETRIES, increment retry and return to the same byte's SEND state. Otherwise set the error flag and go to DONE.
  - If an ack and the timeout occur in the same cycle, the ack wins.
  - An LED retry after the argument fails resends the argument only, not 0xED.
- Timer: counter of width $clog2(ACK_TIMEOUT). Counts only in WAIT states and saturates at its terminal value.
- IDLE arbitration, fixed priority led > host, evaluated in one cycle:
  - If led_valid: led_ready=1, latch led_state, command_byte=0xED, go to SEND_CMD.
  - Else if host_valid: host_ready=1, latch host_byte, go to SEND_CMD.
  - The ready pulse lasts exactly one cycle, in IDLE only. The latched request is immune to later input changes.
- DONE (1 cycle): done_valid=1 with done_error/done_source valid, then go to IDLE. There is no backpressure on done.
- Boot: a boot failure still passes through DONE with done_source=0 and done_error=1, then goes to IDLE. There is no automatic reboot.
- Requests arriving while busy wait; they are never dropped.
- Unsolicited command_ack_valid in non-WAIT states: command_ack_ready=0 (left pending).
- Asserting reset mid-transaction aborts immediately and restarts boot. The protocol engine is reset together with this block.

Decomposition:
- Shared package ps2_pkg holds:
  - PS2_CMD_RESET=8'hFF, PS2_CMD_SET_LEDS=8'hED
  - the state enum type
  - the source encoding constants (SRC_BOOT/SRC_LED/SRC_HOST)
- No sub-module needed. The timeout counter stays inline.

Test Plan:
- Reset release with an immediate ack (error=0) → command_byte=0xFF handshake. Then done_valid with source=0, error=0; busy falls the next cycle.
- led_valid with led_state=3'b101 → bytes 0xED then 0x05, each acked. done source=1, error=0. led_ready is high for exactly 1 cycle.
- led_valid and host_valid asserted together (host_byte=0xF4) → LED transaction completes first, then 0xF4 is sent. done sources are 1 then 2.
- host 0xF4 with MAX_RETRIES=3: ack_error on three attempts, success on the fourth → four 0xF4 handshakes and done error=0. With four errors → exactly 4 handshakes and done error=1.
- ACK_TIMEOUT=16, no ack ever → retransmission after 16 wait cycles each time. After 1+MAX_RETRIES attempts, done error=1.
- Reset asserted during WAIT_ARG → outputs return to reset values asynchronously, and boot 0xFF is reissued after release.
